fir_coeff_loader: RTL and testbench
===================================

// Module: fir_coeff_loader
// PURPOSE
//  Initiator for the FIR coefficient reload port. Nios writes a coefficient
//  set into a local staging register file; a start pulse then burst-writes
//  all coefficients into the FIR and reads each one back for verification.
//  Sits between the Nios Avalon-MM control bridge and the fir coeff_in/out ports.
// PARAMETERS
//  NUM_COEFFS  64   coefficients per set (addresses 0..NUM_COEFFS-1)
//  ADDR_W      6    coefficient address width, 2**ADDR_W >= NUM_COEFFS
//  COEFF_W     16   coefficient width
//  RD_TIMEOUT  15   max cycles to wait for coeff_out_valid per read
// PORTS
//  clk              in   1        single clock, also drives FIR coeff_in_clk
//  reset            in   1        synchronous, active-high
//  stage_we         in   1        write staging entry (ignored while busy)
//  stage_addr       in   ADDR_W   staging entry index
//  stage_data       in   COEFF_W  staging entry value
//  start            in   1        one-cycle pulse: begin load+verify (ignored while busy)
//  busy             out  1        high from cycle after start until DONE/ERROR
//  done             out  1        sticky: last run verified OK; cleared by start
//  error            out  1        sticky: mismatch or timeout; cleared by start
//  err_timeout      out  1        sticky: error cause was timeout (0 = mismatch)
//  err_addr         out  ADDR_W   address of first failing coefficient
//  coeff_in_address out  ADDR_W   FIR coefficient address
//  coeff_in_we      out  1        FIR coefficient write strobe
//  coeff_in_data    out  COEFF_W  FIR coefficient write data
//  coeff_in_read    out  1        FIR coefficient read strobe
//  coeff_out_valid  in   1        FIR read data valid
//  coeff_out_data   in   COEFF_W  FIR read data
// BEHAVIOUR
//  Reset: all outputs 0, FSM->IDLE, counters 0. Staging array is NOT reset;
//   contents survive reset. Reset mid-run aborts immediately, no further strobes.
//  Staging: stage_we in IDLE/DONE/ERROR writes array[stage_addr] at the edge;
//   stage_addr >= NUM_COEFFS dropped. stage_we while busy dropped.
//  stage_we and start in same cycle: write lands first; run uses new value.
//  FSM: IDLE -> WRITE on start; WRITE -> RD_REQ after addr NUM_COEFFS-1;
//   RD_REQ -> RD_WAIT; RD_WAIT -> RD_REQ (match, addr<last) | FIN (match, last)
//   | ERROR (mismatch or timeout); FIN -> IDLE with done=1; ERROR -> IDLE.
//  WRITE: start seen at cycle 0 -> coeff_in_we=1 cycles 1..NUM_COEFFS, one addr
//   per cycle ascending from 0, coeff_in_data = array[addr]. No gaps.
//  RD_REQ: coeff_in_read=1 for exactly one cycle with coeff_in_address=addr;
//   never overlaps coeff_in_we. Only one read outstanding.
//  RD_WAIT: counter starts 0 the cycle after read strobe; on coeff_out_valid
//   compare coeff_out_data to array[addr]. Valid arriving in RD_REQ cycle ignored.
//   Counter reaching RD_TIMEOUT without valid -> timeout error.
//  Stray coeff_out_valid outside RD_WAIT ignored.
//  Error: err_addr=failing addr, err_timeout set per cause, error=1, busy=0
//   next cycle; remaining addresses not checked; FIR keeps written values.
//  done/error mutually exclusive; both cleared on the accepted start edge.
//  Strobe outputs (we/read) are 0 whenever FSM is not in WRITE/RD_REQ;
//   address/data outputs hold last value.
//  FIR read latency L (cycles from read strobe to valid): clean run takes
//   NUM_COEFFS + NUM_COEFFS*(L+1) + 1 cycles start->done.
// TESTING
//  1 Stage 0..63 = 0x0100+i, start, FIR model L=2 -> 64 contiguous writes addr
//    0..63 data 0x0100..0x013F, 64 reads, done=1 at cycle 64+64*3+1=257, error=0.
//  2 FIR model corrupts addr 17 readback to 0xDEAD -> error=1, err_addr=17,
//    err_timeout=0, no read strobe after addr 17, done=0.
//  3 FIR model never asserts valid for addr 5 -> error=1, err_timeout=1,
//    err_addr=5 after 15 wait cycles.
//  4 start and stage_we(addr0=0x7777) same cycle -> first write carries 0x7777;
//    second start during busy and stage_we during busy ignored (array unchanged).
//  5 reset asserted during WRITE at addr 30 -> next cycle we/read=0, busy=0,
//    done=error=0; new start reloads all 64 from addr 0 with preserved staging.
//  6 After error, start again with good model -> error clears on start, done=1.

Source files
------------

// File: rtl/fir_coeff_loader_if.sv
// FIR coefficient reload port: write/read strobes toward the FIR and read data back.
// The loader drives the master side; the FIR (or its model) sits on the slave side.
interface fir_coeff_loader_if #(
    parameter int ADDR_W  = 6,
    parameter int COEFF_W = 16
);
    logic [ADDR_W-1:0]  coeff_in_address;
    logic               coeff_in_we;
    logic [COEFF_W-1:0] coeff_in_data;
    logic               coeff_in_read;
    logic               coeff_out_valid;
    logic [COEFF_W-1:0] coeff_out_data;

    modport master (
        output coeff_in_address, coeff_in_we, coeff_in_data, coeff_in_read,
        input  coeff_out_valid, coeff_out_data
    );

    modport slave (
        input  coeff_in_address, coeff_in_we, coeff_in_data, coeff_in_read,
        output coeff_out_valid, coeff_out_data
    );
endinterface

// File: rtl/fir_coeff_loader.sv
// Stages a coefficient set locally, then burst-writes it into the FIR and
// reads every coefficient back, flagging the first mismatch or read timeout.
module fir_coeff_loader #(
    parameter int NUM_COEFFS = 64,
    parameter int ADDR_W     = 6,
    parameter int COEFF_W    = 16,
    parameter int RD_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stage_we,
    input  logic [ADDR_W-1:0]  stage_addr,
    input  logic [COEFF_W-1:0] stage_data,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               err_timeout,
    output logic [ADDR_W-1:0]  err_addr,
    fir_coeff_loader_if.master fir
);
    localparam int WAIT_W = $clog2(RD_TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_COEFFS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WRITE, RD_REQ, RD_WAIT, FIN, ERROR} state_t;

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [WAIT_W-1:0]  wait_reg, wait_next;
    logic [COEFF_W-1:0] data_reg, exp_reg;
    logic               done_reg, done_next;
    logic               error_reg, error_next;
    logic               err_to_reg, err_to_next;
    logic [ADDR_W-1:0]  err_addr_reg, err_addr_next;
    logic               load_data, load_exp;
    logic [ADDR_W-1:0]  rd_idx;
    logic               busy_int, stage_wr, fwd_hit;

    logic [COEFF_W-1:0] stage_mem [NUM_COEFFS];

    assign busy_int = (state_reg == WRITE) || (state_reg == RD_REQ) || (state_reg == RD_WAIT);
    assign stage_wr = stage_we && !busy_int && (int'(stage_addr) < NUM_COEFFS);
    // A staging write coinciding with start must reach the first burst word.
    assign fwd_hit  = stage_wr && (stage_addr == rd_idx);

    // Staging contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (stage_wr) stage_mem[stage_addr] <= stage_data;
    end

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        wait_next     = wait_reg;
        done_next     = done_reg;
        error_next    = error_reg;
        err_to_next   = err_to_reg;
        err_addr_next = err_addr_reg;
        load_data     = 1'b0;
        load_exp      = 1'b0;
        rd_idx        = '0;
        case (state_reg)
            WRITE: begin
                if (addr_reg == LAST_ADDR) begin
                    state_next = RD_REQ;
                    addr_next  = '0;
                    load_exp   = 1'b1;
                end else begin
                    addr_next  = addr_reg + 1'b1;
                    rd_idx     = addr_reg + 1'b1;
                    load_data  = 1'b1;
                end
            end
            RD_REQ: begin
                state_next = RD_WAIT;
                wait_next  = '0;
            end
            RD_WAIT: begin
                if (fir.coeff_out_valid) begin
                    if (fir.coeff_out_data != exp_reg) begin
                        state_next    = ERROR;
                        error_next    = 1'b1;
                        err_to_next   = 1'b0;
                        err_addr_next = addr_reg;
                    end else if (addr_reg == LAST_ADDR) begin
                        state_next = FIN;
                        done_next  = 1'b1;
                    end else begin
                        state_next = RD_REQ;
                        addr_next  = addr_reg + 1'b1;
                        rd_idx     = addr_reg + 1'b1;
                        load_exp   = 1'b1;
                    end
                end else if (wait_reg == WAIT_LAST) begin
                    state_next    = ERROR;
                    error_next    = 1'b1;
                    err_to_next   = 1'b1;
                    err_addr_next = addr_reg;
                end else begin
                    wait_next = wait_reg + 1'b1;
                end
            end
            default: begin
                // IDLE, FIN and ERROR all accept a new run.
                if (start) begin
                    state_next    = WRITE;
                    addr_next     = '0;
                    done_next     = 1'b0;
                    error_next    = 1'b0;
                    err_to_next   = 1'b0;
                    err_addr_next = '0;
                    load_data     = 1'b1;
                end else if (state_reg != IDLE) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg     <= '0;
            wait_reg     <= '0;
            data_reg     <= '0;
            exp_reg      <= '0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
            err_to_reg   <= 1'b0;
            err_addr_reg <= '0;
        end else begin
            addr_reg     <= addr_next;
            wait_reg     <= wait_next;
            done_reg     <= done_next;
            error_reg    <= error_next;
            err_to_reg   <= err_to_next;
            err_addr_reg <= err_addr_next;
            if (load_data) data_reg <= fwd_hit ? stage_data : stage_mem[rd_idx];
            if (load_exp)  exp_reg  <= stage_mem[rd_idx];
        end
    end

    assign busy                 = busy_int;
    assign done                 = done_reg;
    assign error                = error_reg;
    assign err_timeout          = err_to_reg;
    assign err_addr             = err_addr_reg;
    assign fir.coeff_in_address = addr_reg;
    assign fir.coeff_in_data    = data_reg;
    assign fir.coeff_in_we      = (state_reg == WRITE);
    assign fir.coeff_in_read    = (state_reg == RD_REQ);
endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader: a FIR model answers reads, and a
// scoreboard queue holds the expected write/read strobes of each run.
module tb_fir_coeff_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic        stage_we;
    logic [5:0]  stage_addr;
    logic [15:0] stage_data;
    logic        start;
    logic        busy, done, error, err_timeout;
    logic [5:0]  err_addr;

    fir_coeff_loader_if #(.ADDR_W(6), .COEFF_W(16)) fir_if ();

    fir_coeff_loader #(.NUM_COEFFS(64), .ADDR_W(6), .COEFF_W(16), .RD_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .stage_we(stage_we), .stage_addr(stage_addr),
        .stage_data(stage_data), .start(start), .busy(busy), .done(done),
        .error(error), .err_timeout(err_timeout), .err_addr(err_addr), .fir(fir_if)
    );

    always #5 clk = ~clk;

    typedef struct { logic [5:0] a; logic [15:0] d; } wr_t;
    wr_t         wr_q [$];
    int          rd_q [$];
    logic [15:0] stg [64];
    logic [15:0] fir_mem [64];
    int          n_vec = 0;
    int          n_err = 0;

    bit          corrupt_en = 0, drop_en = 0;
    int          corrupt_addr = 0, drop_addr = 0;
    int          rd_cnt = 0, rd_addr = 0;
    int          lat = 2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // FIR model: read data appears 'lat' cycles after the read strobe.
    initial begin
        fir_if.coeff_out_valid = 1'b0;
        fir_if.coeff_out_data  = '0;
        forever begin
            @(negedge clk);
            fir_if.coeff_out_valid = 1'b0;
            if (reset) rd_cnt = 0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0 && !(drop_en && rd_addr == drop_addr)) begin
                    fir_if.coeff_out_valid = 1'b1;
                    fir_if.coeff_out_data  = (corrupt_en && rd_addr == corrupt_addr) ? 16'hDEAD : fir_mem[rd_addr];
                end
            end
            if (fir_if.coeff_in_read) begin
                rd_addr = int'(fir_if.coeff_in_address);
                rd_cnt  = lat;
            end
            if (fir_if.coeff_in_we) fir_mem[fir_if.coeff_in_address] = fir_if.coeff_in_data;
        end
    end

    // Scoreboard: every strobe pops its expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (fir_if.coeff_in_we && fir_if.coeff_in_read) chk("we_read_overlap", 1, 0);
            if (fir_if.coeff_in_we) begin
                if (wr_q.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    chk("wr_addr", 32'(fir_if.coeff_in_address), 32'(e.a));
                    chk("wr_data", 32'(fir_if.coeff_in_data), 32'(e.d));
                end
            end
            if (fir_if.coeff_in_read) begin
                if (rd_q.size() == 0) chk("unexpected_read", 1, 0);
                else chk("rd_addr", 32'(fir_if.coeff_in_address), 32'(rd_q.pop_front()));
            end
        end
    end

    task automatic stage(input int a, input logic [15:0] d);
        @(negedge clk);
        stage_we = 1'b1; stage_addr = 6'(a); stage_data = d;
        stg[a] = d;
        @(negedge clk);
        stage_we = 1'b0;
    endtask

    task automatic push_run(input int n_wr, input int n_rd);
        for (int i = 0; i < n_wr; i++) wr_q.push_back('{a: 6'(i), d: stg[i]});
        for (int i = 0; i < n_rd; i++) rd_q.push_back(i);
    endtask

    // Start a run (optionally with a same-cycle staging write to addr 0 and a
    // mid-run start/stage poke) and check when and how it finishes.
    task automatic run(input string tag, input int exp_cyc, input bit exp_err, input bit exp_to,
                       input int exp_eaddr, input bit with_stage0, input int poke);
        int  n;
        bit  seen;
        @(negedge clk);
        start = 1'b1;
        if (with_stage0) begin
            stage_we = 1'b1; stage_addr = 6'd0; stage_data = 16'h7777;
        end
        @(posedge clk);
        n = 0; seen = 0;
        while (n < 2000 && !seen) begin
            @(negedge clk);
            n++;
            start = 1'b0; stage_we = 1'b0;
            if (n == 1) begin
                chk({tag, "_busy1"}, 32'(busy), 1);
                chk({tag, "_flags_clr"}, {30'd0, done, error}, 0);
            end
            if (poke != 0 && n == poke) begin
                start = 1'b1; stage_we = 1'b1; stage_addr = 6'd1; stage_data = 16'hBEEF;
            end
            if (done || error) seen = 1;
        end
        chk({tag, "_finished"}, 32'(seen), 1);
        chk({tag, "_cycle"}, n, exp_cyc);
        chk({tag, "_done"}, 32'(done), 32'(!exp_err));
        chk({tag, "_error"}, 32'(error), 32'(exp_err));
        if (exp_err) begin
            chk({tag, "_err_timeout"}, 32'(err_timeout), 32'(exp_to));
            chk({tag, "_err_addr"}, 32'(err_addr), exp_eaddr);
        end
        chk({tag, "_busy0"}, 32'(busy), 0);
        repeat (20) @(negedge clk);
        chk({tag, "_wr_left"}, wr_q.size(), 0);
        chk({tag, "_rd_left"}, rd_q.size(), 0);
        wr_q.delete(); rd_q.delete();
    endtask

    initial begin
        int n;
        start = 0; stage_we = 0; stage_addr = 0; stage_data = 0; reset = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_err_to", 32'(err_timeout), 0);
        chk("rst_err_addr", 32'(err_addr), 0);
        chk("rst_we", 32'(fir_if.coeff_in_we), 0);
        chk("rst_read", 32'(fir_if.coeff_in_read), 0);
        chk("rst_addr", 32'(fir_if.coeff_in_address), 0);
        chk("rst_data", 32'(fir_if.coeff_in_data), 0);
        reset = 0;
        for (int i = 0; i < 64; i++) stage(i, 16'(16'h0100 + i));

        push_run(64, 64);
        run("clean", 257, 0, 0, 0, 0, 0);

        corrupt_en = 1; corrupt_addr = 17;
        push_run(64, 18);
        run("mismatch", 68 + 3 * 17, 1, 0, 17, 0, 0);
        corrupt_en = 0;

        drop_en = 1; drop_addr = 5;
        push_run(64, 6);
        run("timeout", 96, 1, 1, 5, 0, 0);
        drop_en = 0;

        push_run(64, 64);
        run("recover", 257, 0, 0, 0, 0, 0);

        stg[0] = 16'h7777;
        push_run(64, 64);
        run("stage_start", 257, 0, 0, 0, 1, 10);
        push_run(64, 64);
        run("busy_ignored", 257, 0, 0, 0, 0, 0);

        // Abort with reset while writing address 30.
        push_run(31, 0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        n = 0;
        while (n < 100 && !(fir_if.coeff_in_we && fir_if.coeff_in_address == 6'd30)) begin
            @(negedge clk);
            n++;
            start = 1'b0;
        end
        chk("abort_cycle", n, 31);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_we", 32'(fir_if.coeff_in_we), 0);
        chk("abort_read", 32'(fir_if.coeff_in_read), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_flags", {30'd0, done, error}, 0);
        repeat (5) @(negedge clk);
        chk("abort_wr_left", wr_q.size(), 0);
        push_run(64, 64);
        run("reload", 257, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
